// File: rtl/pipelined_cia_adder_if.sv
// Valid/ready operand/result bus for pipelined_cia_adder.
// The sat input exists only when CIA_SATURATE_EN is defined.
interface pipelined_cia_adder_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in1, in2;
  logic             cin, sub;
`ifdef CIA_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry, overflow;

`ifdef CIA_SATURATE_EN
  modport master (output in_valid, in1, in2, cin, sub, sat, out_ready,
                  input  in_ready, out_valid, sum, carry, overflow);
  modport slave  (input  in_valid, in1, in2, cin, sub, sat, out_ready,
                  output in_ready, out_valid, sum, carry, overflow);
`else
  modport master (output in_valid, in1, in2, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, carry, overflow);
  modport slave  (input  in_valid, in1, in2, cin, sub, out_ready,
                  output in_ready, out_valid, sum, carry, overflow);
`endif
endinterface

// File: rtl/pipelined_cia_adder.sv
// Pipelined carry-increment adder/subtractor with valid/ready flow control.
// Optional CIA_SATURATE_EN adds a per-operand sat flag that clamps on overflow.
module pipelined_cia_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cia_adder_if.slave bus
);
  localparam int NB  = WIDTH / BLOCK;
  localparam int SEG = NB / STAGES;

  logic [STAGES:1]  vld_pipe, vld_d, rdy;
  logic [WIDTH-1:0] sum_q [1:STAGES];
  logic [WIDTH-1:0] sum_d [1:STAGES];
  logic [NB-1:0]    lc_q  [1:STAGES];
  logic [NB-1:0]    lc_d  [1:STAGES];
  logic [STAGES:1]  cc_q, cc_d, am_q, am_d, bm_q, bm_d;
  logic             ovf_q, ovf_d;
`ifdef CIA_SATURATE_EN
  logic [STAGES:1]  sat_q, sat_d;
`endif

  always_comb begin
    logic [WIDTH-1:0] beff, s;
    logic [NB-1:0]    lc;
    logic [BLOCK:0]   t;
    logic [BLOCK-1:0] ls;
    logic             c, am, bm, r, st;
    int               p;
    // Ready ripples back from the output: a stage can load if empty or draining.
    r = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      r      = !vld_pipe[k] || r;
      rdy[k] = r;
    end
    beff = bus.sub ? ~bus.in2 : bus.in2;
    s    = '0;
    lc   = '0;
    for (int b = 0; b < NB; b++) begin
      t = {1'b0, bus.in1[b*BLOCK +: BLOCK]} + {1'b0, beff[b*BLOCK +: BLOCK]}
        + (BLOCK+1)'((b == 0) ? (bus.cin ^ bus.sub) : 1'b0);
      s[b*BLOCK +: BLOCK] = t[BLOCK-1:0];
      lc[b]               = t[BLOCK];
    end
    c  = 1'b0;
    am = bus.in1[WIDTH-1];
    bm = beff[WIDTH-1];
`ifdef CIA_SATURATE_EN
    st = bus.sat;
`else
    st = 1'b0;
`endif
    for (int k = 1; k <= STAGES; k++) begin
      p = (k > 1) ? k - 1 : 1;
      vld_d[k] = (k == 1) ? bus.in_valid : vld_pipe[p];
      if (k > 1) begin
        s  = sum_q[p];
        lc = lc_q[p];
        c  = cc_q[p];
        am = am_q[p];
        bm = bm_q[p];
`ifdef CIA_SATURATE_EN
        st = sat_q[p];
`endif
      end
      // Resolve this stage's segment; the last segment absorbs remainder blocks.
      for (int b = 0; b < NB; b++) begin
        if (b >= (k-1)*SEG && (b < k*SEG || k == STAGES)) begin
          ls = s[b*BLOCK +: BLOCK];
          s[b*BLOCK +: BLOCK] = ls + BLOCK'(c);
          c = lc[b] | (c & (&ls));
        end
      end
      sum_d[k] = s;
      lc_d[k]  = lc;
      cc_d[k]  = c;
      am_d[k]  = am;
      bm_d[k]  = bm;
`ifdef CIA_SATURATE_EN
      sat_d[k] = st;
`endif
    end
    ovf_d = (am == bm) && (s[WIDTH-1] != am);
    if (st && ovf_d)
      sum_d[STAGES] = am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      cc_q     <= '0;
      am_q     <= '0;
      bm_q     <= '0;
      ovf_q    <= 1'b0;
`ifdef CIA_SATURATE_EN
      sat_q    <= '0;
`endif
      for (int k = 1; k <= STAGES; k++) begin
        sum_q[k] <= '0;
        lc_q[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= vld_d[k];
          sum_q[k]    <= sum_d[k];
          lc_q[k]     <= lc_d[k];
          cc_q[k]     <= cc_d[k];
          am_q[k]     <= am_d[k];
          bm_q[k]     <= bm_d[k];
`ifdef CIA_SATURATE_EN
          sat_q[k]    <= sat_d[k];
`endif
        end
      end
      if (rdy[STAGES]) ovf_q <= ovf_d;
    end
  end

  // Handshakes are suppressed while reset is asserted.
  assign bus.in_ready  = rdy[1] & ~rst;
  assign bus.out_valid = vld_pipe[STAGES] & ~rst;
  assign bus.sum       = sum_q[STAGES];
  assign bus.carry     = cc_q[STAGES];
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_cia_adder.sv
// Bench for pipelined_cia_adder: directed vectors, backpressure and random streaming.
module tb_pipelined_cia_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
`ifdef CIA_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sat_r;
  always #5 clk = ~clk;

  pipelined_cia_adder_if #(.WIDTH(WIDTH)) bus();
`ifdef CIA_SATURATE_EN
  assign bus.sat = sat_r;
`endif

  pipelined_cia_adder #(.WIDTH(WIDTH), .BLOCK(4), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub, sat;
    logic [31:0] s;
    logic        c, ov;
  } vec_t;
  typedef struct { logic [31:0] s; logic c, ov; } res_t;

  res_t q[$];
  int   checks = 0, errors = 0, n_acc = 0;

  // Reference: plain wide arithmetic on the conditioned operands.
  function automatic res_t model(logic [31:0] a, b, logic cin, sub, sat);
    logic [32:0] full;
    logic [31:0] be;
    res_t        r;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + 33'(cin ^ sub);
    r.s  = full[31:0];
    r.c  = full[32];
    r.ov = (a[31] == be[31]) && (r.s[31] != a[31]);
    if (SAT_EN && sat && r.ov) r.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] a, b, logic ci, sb, st, ordy);
    bus.in_valid  = v;
    bus.in1       = a;
    bus.in2       = b;
    bus.cin       = ci;
    bus.sub       = sb;
    sat_r         = st;
    bus.out_ready = ordy;
  endtask

  // Called just after a negedge with inputs driven; scores one clock cycle.
  task automatic tick(string tag);
    res_t e;
    #1;
    if (rst) begin
      chk({tag, "_rst_out_valid"}, 64'(bus.out_valid), 64'd0);
      q.delete();
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_spurious: out_valid=1 expected 0", tag);
        end else begin
          e = q[0];
          chk({tag, "_sum"},   64'(bus.sum),      64'(e.s));
          chk({tag, "_carry"}, 64'(bus.carry),    64'(e.c));
          chk({tag, "_ovf"},   64'(bus.overflow), 64'(e.ov));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in1, bus.in2, bus.cin, bus.sub, sat_r));
        n_acc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl[12];
    int          lat, acc, cyc;
    logic [31:0] a, b;

    tbl[0]  = '{32'h0000000F, 32'h00000001, 0, 0, 0, 32'h00000010, 0, 0};
    tbl[1]  = '{32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 32'h00000000, 1, 0};
    tbl[2]  = '{32'h00000005, 32'h00000007, 0, 1, 0, 32'hFFFFFFFE, 0, 0};
    tbl[3]  = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 32'h80000000, 0, 1};
    tbl[4]  = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 32'h00000000, 1, 0};
    tbl[5]  = '{32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 32'hACF13568, 0, 0};
    tbl[6]  = '{32'h00000000, 32'h00000000, 0, 1, 0, 32'h00000000, 1, 0};
    tbl[7]  = '{32'h80000000, 32'h80000000, 0, 0, 0, 32'h00000000, 1, 1};
    tbl[8]  = '{32'h0000FFFF, 32'h00000001, 0, 0, 0, 32'h00010000, 0, 0};
    tbl[9]  = '{32'h80000000, 32'h00000001, 0, 1, 0, 32'h7FFFFFFF, 1, 1};
    tbl[10] = '{32'h80000000, 32'h00000001, 0, 1, 1,
                SAT_EN ? 32'h80000000 : 32'h7FFFFFFF, 1, 1};
    tbl[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 1,
                SAT_EN ? 32'h7FFFFFFF : 32'hFFFFFFFF, 0, 1};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_sum",       64'(bus.sum),       64'd0);
    chk("post_rst_carry",     64'(bus.carry),     64'd0);
    chk("post_rst_ovf",       64'(bus.overflow),  64'd0);
    chk("post_rst_in_ready",  64'(bus.in_ready),  64'd1);

    // Directed vectors with exact-latency check.
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat, 1);
      #1 chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      lat = 1;
      while (!bus.out_valid && lat < 8) begin
        @(negedge clk); #1;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat),          64'(STAGES));
      chk($sformatf("vec%0d_sum", i),     64'(bus.sum),      64'(tbl[i].s));
      chk($sformatf("vec%0d_carry", i),   64'(bus.carry),    64'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i),     64'(bus.overflow), 64'(tbl[i].ov));
    end

    // Backpressure: fill with out_ready=0, hold, then accept+drain together.
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 * (i + 1), 32'h11 * (i + 1), 0, 0, 0, 0);
      #1 chk($sformatf("bp_in_ready%0d", i), 64'(bus.in_ready), (i < STAGES) ? 64'd1 : 64'd0);
      if (bus.in_ready) acc++;
      tick("bp_fill");
    end
    chk("bp_accepts", 64'(acc), 64'(STAGES));
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick("bp_hold");
    drive(1, 32'hDEADBEEF, 32'h01234567, 1, 1, 0, 1);
    #1 chk("bp_full_in_ready", 64'(bus.in_ready), 64'd1);
    tick("bp_swap");
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < STAGES; i++) begin
      #1 chk($sformatf("bp_drain_valid%0d", i), 64'(bus.out_valid), 64'd1);
      tick("bp_drain");
    end
    #1 chk("bp_empty_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // Random stream with a mid-stream reset.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      rst = (cyc == 400);
      case ($urandom_range(0, 3))
        0: begin a = 32'hFFFFFFFF; b = $urandom_range(0, 1); end
        1: begin a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFFFFFF}; b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      drive(($urandom_range(0, 3) != 0), a, b, 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 2) != 0));
      if (cyc == 401) begin
        #1 chk("rnd_after_rst_out_valid", 64'(bus.out_valid), 64'd0);
      end
      tick("rnd");
      cyc++;
    end
    rst = 1'b0;
    chk("rnd_stream_done", 64'(n_acc >= 1000), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      tick("rnd_drain");
      cyc++;
    end
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_cia_adder.md
Name: pipelined_cia_adder

Overview:
- Parametrised, pipelined carry-increment adder/subtractor.
- Generalised successor of the fixed 32-bit carry-increment adder, with configurable width and block size.
- Splits the block-to-block increment chain across STAGES register stages and carries operands through a valid/ready pipeline with backpressure.
- Serves as the datapath adder for ALU and accumulator blocks that need registered, flow-controlled results.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, ripple-carry block width in bits. NB = WIDTH/BLOCK.
- STAGES, 2, pipeline depth. Legal range 1..NB. Blocks are partitioned evenly into STAGES segments; any remainder blocks go to the last segment.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input operands valid
- in_ready  output  1  block can accept operands this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry in
- sub  input  1  1 = A - B, 0 = A + B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- carry  output  1  carry out of MSB (for subtract, 1 = no borrow)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, sum=0, carry=0, overflow=0, all stage valid bits 0. in_ready=1 in the first cycle after reset is released.
- Reset mid-operation discards every in-flight result. No output handshake fires in the reset cycle.
- Operand conditioning:
  - Effective B = sub ? ~in2 : in2.
  - Effective carry in c0 = cin ^ sub.
  - Result = A + B_eff + c0, modulo 2^WIDTH.
  - carry = bit WIDTH of that sum.
  - overflow = (A[MSB] == B_eff[MSB]) && (sum[MSB] != A[MSB]).
- Datapath, stage 1:
  - Every block computes its local BLOCK-bit sum and carry with carry-in 0.
  - Block 0 uses c0 as its carry-in.
  - The increment chain then resolves the first segment of blocks.
- Datapath, later stages:
  - Each later stage resolves its segment of blocks.
  - A block is incremented by 1 when the incoming chained carry is 1.
  - Outgoing carry = local_carry | (incoming_carry & (local_sum == all-ones)).
- Registers: one register set per stage. Each holds a valid bit, the partially resolved sums, the pending local carries, the chained carry, and the sign bits needed for overflow.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Stage k advances when stage k+1 is empty or advancing.
  - in_ready = stage 1 empty or stage 1 advancing. in_ready is combinational from out_ready; this is allowed.
  - Holding out_ready=1 gives latency of exactly STAGES cycles from the accepting edge to out_valid=1.
  - Throughput is 1 result per cycle.
- Backpressure:
  - While out_valid=1 && out_ready=0, sum, carry and overflow hold stable.
  - After STAGES accepted transfers with no drain, in_ready=0.
- Simultaneous accept and drain when full: both occur in the same cycle, with no bubble and no data loss.
- Ordering: strictly FIFO; no reordering.
- in_valid=0: stage valid bits propagate as 0 (bubbles). Datapath registers may hold stale data. Outputs are only meaningful while out_valid=1.
- Wrap-around: 0xFFFFFFFF + 1 produces sum 0 and carry 1. The all-ones increment propagates across every block, including across stage boundaries.
- STAGES=1: the whole chain is resolved in a single stage with one output register, so latency is 1.

Optional Feature:
- Macro name: CIA_SATURATE_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands.
  - When sat=1 and overflow=1, sum is clamped: positive overflow gives 0x7FF..F, negative overflow gives 0x800..0.
  - overflow still reports 1. carry is unaffected.
  - Clamping is applied in the last stage, with no added latency.
- Not defined: the sat port is absent and sum always wraps modulo 2^WIDTH.

Test Plan:
- Reset release, WIDTH=32, STAGES=2: in1=0x0000000F, in2=0x00000001, sub=0, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x00000010, carry=0, overflow=0.
- Full carry propagation: in1=0xFFFFFFFF, in2=0x00000000, cin=1 -> sum=0x00000000, carry=1, overflow=0. Increment crosses the stage boundary correctly.
- Subtract with borrow: in1=5, in2=7, sub=1 -> sum=0xFFFFFFFE, carry=0, overflow=0. Signed overflow: in1=0x7FFFFFFF, in2=1, sub=0 -> sum=0x80000000, overflow=1.
- Backpressure: hold out_ready=0 and issue 3 transfers -> in_ready=0 after 2 accepts, first result held stable. Raise out_ready -> results emerge in order, one per cycle, with no loss or duplication.
- Streaming 1000 random operand pairs with random in_valid and out_ready, plus rst asserted mid-stream -> each output matches the reference model in order. Cycle after rst: out_valid=0 and in-flight results are dropped.
- With CIA_SATURATE_EN and sat=1: in1=0x80000000, in2=1, sub=1 -> sum=0x80000000, overflow=1. Same stimulus with sat=0 -> sum=0x7FFFFFFF.
